dmem_responder: RTL and testbench

Data-memory responder for the core's dm_* port: the slave end of the interface driven by the core (address, 32-bit bit-mask write enable, write data, read data).
- Word-addressed synchronous RAM, plus a small MMIO page: GPIO output register, free-running cycle counter, sticky error/status register.
- Sits beside the core in the top level; its dm_dout_o connects directly to the core's dm_dout_i.

---
 rtl/dmem_responder_if.sv | 9 +
 rtl/dmem_responder.sv | 54 +++++
 tb/tb_dmem_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core data-memory port bundle (core is master, responder is slave)
interface dmem_responder_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wen_i;
  logic [31:0] dm_din_i;
  logic [31:0] dm_dout_o;
  modport master (output dm_addr_i, dm_wen_i, dm_din_i, input dm_dout_o);
  modport slave (input dm_addr_i, dm_wen_i, dm_din_i, output dm_dout_o);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus GPIO/CYCLE/STATUS MMIO page, 1-cycle registered read, write-first
module dmem_responder #(
  parameter int          RAM_AW   = 10,
  parameter logic [31:0] GPIO_RST = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  dmem_responder_if.slave   dm,
  output logic [31:0]       gpio_o,
  output logic              err_o
);
  logic [31:0]       r_ram [2**RAM_AW];
  logic [31:0]       r_dout, r_gpio, r_cycle;
  logic              r_err;
  logic              w_wr, w_ram, w_in, w_gpio, w_cyc, w_st, w_ram_wr, w_err_new;
  logic [RAM_AW-1:0] w_idx;
  logic [31:0]       w_ram_new, w_gpio_new, w_rd;
  assign w_wr       = |dm.dm_wen_i;
  assign w_ram      = ~dm.dm_addr_i[31];
  assign w_in       = dm.dm_addr_i[30:RAM_AW+2] == '0;
  assign w_idx      = dm.dm_addr_i[RAM_AW+1:2];
  assign w_gpio     = dm.dm_addr_i[31] && dm.dm_addr_i[30:2] == 29'd0;
  assign w_cyc      = dm.dm_addr_i[31] && dm.dm_addr_i[30:2] == 29'd1;
  assign w_st       = dm.dm_addr_i[31] && dm.dm_addr_i[30:2] == 29'd2;
  assign w_ram_wr   = w_wr && w_ram && w_in;
  assign w_ram_new  = (r_ram[w_idx] & ~dm.dm_wen_i) | (dm.dm_din_i & dm.dm_wen_i);
  assign w_gpio_new = w_wr && w_gpio ? (r_gpio & ~dm.dm_wen_i) | (dm.dm_din_i & dm.dm_wen_i) : r_gpio;
  // An out-of-range RAM write and a STATUS clear are mutually exclusive (one address per cycle).
  assign w_err_new  = w_wr && w_ram && !w_in ? 1'b1 :
                      w_st && dm.dm_wen_i[0] && dm.dm_din_i[0] ? 1'b0 : r_err;
  always_comb
    w_rd = w_ram  ? (w_in ? (w_wr ? w_ram_new : r_ram[w_idx]) : 32'd0) :
           w_gpio ? w_gpio_new :
           w_cyc  ? r_cycle :
           w_st   ? {31'd0, w_err_new} : 32'd0;
  // RAM has no reset so contents survive it; a write coinciding with reset is dropped.
  always_ff @(posedge clk_i)
    if (rst_n_i && w_ram_wr) r_ram[w_idx] <= w_ram_new;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_dout  <= 32'd0;
      r_gpio  <= GPIO_RST;
      r_cycle <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_dout  <= w_rd;
      r_gpio  <= w_gpio_new;
      r_cycle <= r_cycle + 32'd1;
      r_err   <= w_err_new;
    end
  assign dm.dm_dout_o = r_dout;
  assign gpio_o       = r_gpio;
  assign err_o        = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench with a behavioural model of the memory map
module tb_dmem_responder;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;
  logic clk = 0, rst_n = 0;
  logic [31:0] gpio;
  logic err;
  dmem_responder_if bus ();
  dmem_responder #(.RAM_AW(10), .GPIO_RST(32'h0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .dm(bus), .gpio_o(gpio), .err_o(err));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] dout;
    bit          dc;
    logic [31:0] gpio;
    bit          err;
    string       tag;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem_m [int];
  logic [31:0] gpio_m = 0, cyc_m = 0;
  bit err_m = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [31:0] d, input string tag);
    exp_t e;
    int idx;
    logic [31:0] rd = 0;
    bit dc = 0;
    bus.dm_addr_i = a;
    bus.dm_wen_i  = w;
    bus.dm_din_i  = d;
    idx = int'(a[11:2]);
    if (!a[31]) begin
      if (a[30:12] == 0) begin
        if (w != 0) begin
          if (mem_m.exists(idx)) mem_m[idx] = (mem_m[idx] & ~w) | (d & w);
          else if (w == ALL) mem_m[idx] = d;
        end
        dc = !mem_m.exists(idx);
        rd = dc ? 32'd0 : mem_m[idx];
      end else begin
        if (w != 0) err_m = 1;
        rd = 0;
      end
    end else if (a[30:2] == 0) begin
      gpio_m = (gpio_m & ~w) | (d & w);
      rd = gpio_m;
    end else if (a[30:2] == 1) rd = cyc_m;
    else if (a[30:2] == 2) begin
      if (w[0] && d[0]) err_m = 0;
      rd = {31'd0, err_m};
    end
    cyc_m++;
    e.dout = rd; e.dc = dc; e.gpio = gpio_m; e.err = err_m; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (!e.dc) chk({e.tag, ".dout"}, bus.dm_dout_o, e.dout);
      chk({e.tag, ".gpio"}, gpio, e.gpio);
      chk({e.tag, ".err"}, {31'd0, err}, {31'd0, e.err});
    end
  end
  initial begin
    logic [31:0] a, w;
    int r, k;
    bus.dm_addr_i = 0; bus.dm_wen_i = 0; bus.dm_din_i = 0;
    repeat (3) @(negedge clk);
    chk("rst.dout", bus.dm_dout_o, 0);
    chk("rst.gpio", gpio, 0);
    chk("rst.err", {31'd0, err}, 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) issue(32'h8000_0004, 0, 0, "cycle_count");
    issue(32'h0000_0000, ALL, 32'h0, "init_w0");
    issue(32'h0000_0010, ALL, 32'hDEAD_BEEF, "w10_full");
    issue(32'h0000_0010, 32'h0000_FFFF, 32'h0000_1234, "w10_mask");
    issue(32'h0000_0010, 0, 0, "r10");
    issue(32'h0000_0020, ALL, 32'hA5A5_A5A5, "rdw20");
    issue(32'h8000_0000, ALL, 32'h0000_00FF, "gpio_w");
    issue(32'h0000_1000, ALL, 32'h1111_1111, "oor_w");
    issue(32'h0000_0000, 0, 0, "w0_kept");
    issue(32'h0000_1000, 0, 0, "oor_r");
    issue(32'h8000_0008, 0, 0, "status_r");
    issue(32'h8000_0008, 1, 1, "status_clr");
    issue(32'h8000_0040, ALL, ALL, "mmio_other");
    force dut.r_cycle = 32'hFFFF_FFFE;
    #1 release dut.r_cycle;
    cyc_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) issue(32'h8000_0004, 0, 0, "cycle_wrap");
    bus.dm_addr_i = 32'h8000_0000; bus.dm_wen_i = ALL; bus.dm_din_i = 32'h0000_1234;
    #2 rst_n = 0;
    #1;
    chk("rst_mid.gpio", gpio, 0);
    chk("rst_mid.dout", bus.dm_dout_o, 0);
    chk("rst_mid.err", {31'd0, err}, 0);
    @(negedge clk);
    bus.dm_wen_i = 0;
    gpio_m = 0; err_m = 0; cyc_m = 0;
    rst_n = 1;
    issue(32'h8000_0004, 0, 0, "cycle_after_rst");
    issue(32'h0000_0010, 0, 0, "ram_persist");
    issue(32'h8000_0000, 0, 0, "gpio_after_rst");
    for (int i = 0; i < 16; i++) issue(32'(i * 4), ALL, $urandom, "rand_init");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      a = r <= 4 ? 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)) :
          r == 5 ? (($urandom & 32'h7FFF_FFFF) | 32'h0000_1000) :
          r == 6 ? 32'h8000_0000 | $urandom_range(0, 3) :
          r == 7 ? 32'h8000_0004 | $urandom_range(0, 3) :
          r == 8 ? 32'h8000_0008 | $urandom_range(0, 3) :
                   32'h8000_000C + 32'($urandom_range(0, 100) * 4);
      k = $urandom_range(0, 3);
      w = k <= 1 ? 32'd0 : k == 2 ? ALL : $urandom;
      issue(a, w, $urandom, "random");
    end
    bus.dm_wen_i = 0;
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
